// File: rtl/fp_cvt_issue.sv
// Issue and writeback stage for the FPU conversion unit: one registered issue
// slot feeding an external converter, a 2-entry response FIFO and sticky fflags.
module fp_cvt_issue #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [63:0]      req_operand,
   input  logic [1:0]       req_in_type,
   input  logic [1:0]       req_out_type,
   input  logic [2:0]       req_rm,
   input  logic [TAG_W-1:0] req_tag,
   input  logic [2:0]       frm,
   input  logic             fflags_clr,
   output logic [63:0]      cvt_operand,
   output logic [1:0]       cvt_in_type,
   output logic [1:0]       cvt_out_type,
   output logic [2:0]       cvt_rm,
   input  logic [31:0]      cvt_result,
   input  logic             cvt_nv,
   input  logic             cvt_of,
   input  logic             cvt_uf,
   input  logic             cvt_nx,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic [4:0]       rsp_flags,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_illegal,
   output logic [4:0]       fflags
);

   typedef struct packed {
      logic [31:0]      result;
      logic [4:0]       flags;
      logic [TAG_W-1:0] tag;
      logic             illegal;
   } entry_t;

   // Valid/ready: a transfer happens on a cycle where valid & ready are both
   // high at the clock edge; valid never waits on ready.
   logic             s1_valid_q, s1_valid_d;
   logic [63:0]      s1_operand_q, s1_operand_d;
   logic [1:0]       s1_in_type_q, s1_in_type_d;
   logic [1:0]       s1_out_type_q, s1_out_type_d;
   logic [2:0]       s1_rm_q, s1_rm_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
   logic             s1_illegal_q, s1_illegal_d;

   entry_t           fifo_q [2];
   entry_t           fifo_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic [4:0]       fflags_q, fflags_d;

   logic             req_fire;
   logic             pop;
   logic             s1_adv;
   logic [2:0]       rm_res;
   logic             rm_illegal;
   entry_t           push_entry;
   entry_t           head;

   assign rm_res     = (req_rm == 3'b111) ? frm : req_rm;
   // FP64 results do not fit the 32-bit result path, so they are rejected too.
   assign rm_illegal = (rm_res == 3'b101) | (rm_res == 3'b110) | (rm_res == 3'b111)
                     | (req_out_type == 2'b01);

   assign rsp_valid = (count_q != 2'd0);
   assign pop       = rsp_valid & rsp_ready;
   assign s1_adv    = s1_valid_q & ((count_q < 2'd2) | pop);
   assign req_ready = ~rst & (~s1_valid_q | s1_adv);
   assign req_fire  = req_valid & req_ready;

   assign push_entry.result  = s1_illegal_q ? 32'h0 : cvt_result;
   assign push_entry.flags   = s1_illegal_q ? 5'b0 : {cvt_nv, 1'b0, cvt_of, cvt_uf, cvt_nx};
   assign push_entry.tag     = s1_tag_q;
   assign push_entry.illegal = s1_illegal_q;

   always_comb begin
      s1_valid_d    = s1_valid_q;
      s1_operand_d  = s1_operand_q;
      s1_in_type_d  = s1_in_type_q;
      s1_out_type_d = s1_out_type_q;
      s1_rm_d       = s1_rm_q;
      s1_tag_d      = s1_tag_q;
      s1_illegal_d  = s1_illegal_q;
      fifo_d[0]     = fifo_q[0];
      fifo_d[1]     = fifo_q[1];

      if (req_fire) begin
         s1_valid_d    = 1'b1;
         s1_operand_d  = req_operand;
         s1_in_type_d  = req_in_type;
         s1_out_type_d = req_out_type;
         s1_rm_d       = rm_res;
         s1_tag_d      = req_tag;
         s1_illegal_d  = rm_illegal;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s1_adv) begin
         fifo_d[wr_ptr_q] = push_entry;
      end
      wr_ptr_d = wr_ptr_q ^ s1_adv;
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d  = count_q + {1'b0, s1_adv} - {1'b0, pop};
      // A clear and a push in the same cycle keep the newly pushed flags.
      fflags_d = (fflags_clr ? 5'b0 : fflags_q) | (s1_adv ? push_entry.flags : 5'b0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q    <= 1'b0;
         s1_operand_q  <= '0;
         s1_in_type_q  <= '0;
         s1_out_type_q <= '0;
         s1_rm_q       <= '0;
         s1_tag_q      <= '0;
         s1_illegal_q  <= 1'b0;
         fifo_q[0]     <= '0;
         fifo_q[1]     <= '0;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         count_q       <= 2'd0;
         fflags_q      <= 5'b0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_operand_q  <= s1_operand_d;
         s1_in_type_q  <= s1_in_type_d;
         s1_out_type_q <= s1_out_type_d;
         s1_rm_q       <= s1_rm_d;
         s1_tag_q      <= s1_tag_d;
         s1_illegal_q  <= s1_illegal_d;
         fifo_q[0]     <= fifo_d[0];
         fifo_q[1]     <= fifo_d[1];
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         fflags_q      <= fflags_d;
      end
   end

   assign cvt_operand  = s1_operand_q;
   assign cvt_in_type  = s1_in_type_q;
   assign cvt_out_type = s1_out_type_q;
   assign cvt_rm       = s1_rm_q;

   assign head        = fifo_q[rd_ptr_q];
   assign rsp_result  = head.result;
   assign rsp_flags   = head.flags;
   assign rsp_tag     = head.tag;
   assign rsp_illegal = head.illegal;
   assign fflags      = fflags_q;

endmodule

// File: tb/tb_fp_cvt_issue.sv
// Bench for fp_cvt_issue: a stub converter, directed requests, and a
// scoreboard monitor that checks every response leaving the FIFO.
module tb_fp_cvt_issue;

   localparam int TAG_W = 5;
   localparam int EW    = 32 + 5 + TAG_W + 1;

   logic             clk;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic [63:0]      req_operand;
   logic [1:0]       req_in_type;
   logic [1:0]       req_out_type;
   logic [2:0]       req_rm;
   logic [TAG_W-1:0] req_tag;
   logic [2:0]       frm;
   logic             fflags_clr;
   logic [63:0]      cvt_operand;
   logic [1:0]       cvt_in_type;
   logic [1:0]       cvt_out_type;
   logic [2:0]       cvt_rm;
   logic [31:0]      cvt_result;
   logic             cvt_nv, cvt_of, cvt_uf, cvt_nx;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_result;
   logic [4:0]       rsp_flags;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_illegal;
   logic [4:0]       fflags;

   int tests_run = 0;
   int tests_failed = 0;
   logic [EW-1:0] exp_q[$];

   fp_cvt_issue #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_operand(req_operand), .req_in_type(req_in_type),
      .req_out_type(req_out_type), .req_rm(req_rm), .req_tag(req_tag),
      .frm(frm), .fflags_clr(fflags_clr),
      .cvt_operand(cvt_operand), .cvt_in_type(cvt_in_type),
      .cvt_out_type(cvt_out_type), .cvt_rm(cvt_rm),
      .cvt_result(cvt_result), .cvt_nv(cvt_nv), .cvt_of(cvt_of),
      .cvt_uf(cvt_uf), .cvt_nx(cvt_nx),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
      .rsp_illegal(rsp_illegal), .fflags(fflags)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub converter: FP64 NaN/Inf produce saturated results; anything else
   // returns operand[31:0] + rm with NX set when rm is nonzero.
   always_comb begin
      cvt_result = cvt_operand[31:0] + {29'b0, cvt_rm};
      cvt_nv     = 1'b0;
      cvt_of     = 1'b0;
      cvt_uf     = 1'b0;
      cvt_nx     = (cvt_rm != 3'b000);
      if (cvt_in_type == 2'b01 && cvt_operand[62:52] == 11'h7FF) begin
         cvt_nx = 1'b0;
         cvt_nv = 1'b1;
         if (cvt_operand[51:0] != 52'h0) begin
            cvt_result = (cvt_out_type == 2'b11) ? 32'hFFFFFFFF : 32'h80000000;
         end else begin
            cvt_of     = 1'b1;
            cvt_result = (cvt_out_type == 2'b11) ? 32'hFFFFFFFF : 32'h7FFFFFFF;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Driver: called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [63:0] op, input logic [1:0] it, input logic [1:0] ot,
                       input logic [2:0] rm, input logic [TAG_W-1:0] tag,
                       input logic [31:0] e_res, input logic [4:0] e_flags, input logic e_ill);
      bit done = 0;
      req_valid    = 1'b1;
      req_operand  = op;
      req_in_type  = it;
      req_out_type = ot;
      req_rm       = rm;
      req_tag      = tag;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (req_ready) begin
            @(posedge clk);
            exp_q.push_back({e_res, e_flags, tag, e_ill});
            done = 1;
         end
      end
      if (!done) begin
         tests_run++;
         tests_failed++;
         $display("FAIL send_timeout: tag %0d not accepted, req_ready %0b expected 1", tag, req_ready);
         @(posedge clk);
      end
      #1;
      req_valid = 1'b0;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
      end
      #1;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL rsp_unexpected: got tag %0d, expected no response", rsp_tag);
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            if ({rsp_result, rsp_flags, rsp_tag, rsp_illegal} !== e) begin
               tests_failed++;
               $display("FAIL rsp: got res %h flags %b tag %0d ill %0b, expected res %h flags %b tag %0d ill %0b",
                        rsp_result, rsp_flags, rsp_tag, rsp_illegal,
                        e[EW-1 -: 32], e[EW-33 -: 5], e[TAG_W:1], e[0]);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      req_valid = 1'b0;
      req_operand = '0;
      req_in_type = '0;
      req_out_type = '0;
      req_rm = '0;
      req_tag = '0;
      frm = 3'b000;
      fflags_clr = 1'b0;
      rsp_ready = 1'b1;
      cycles(3);

      // reset state
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_fflags", fflags, 0);
      check("rst_cvt_operand", cvt_operand, 0);
      rst = 1'b0;
      cycles(1);
      check("idle_req_ready", req_ready, 1);

      // NaN -> INT32, latency 2
      send(64'h7FF8000000000000, 2'b01, 2'b10, 3'b000, 5'd3, 32'h80000000, 5'b10000, 1'b0);
      check("lat_rsp_valid_n1", rsp_valid, 0);
      check("nan_cvt_in_type", cvt_in_type, 2'b01);
      cycles(1);
      check("lat_rsp_valid_n2", rsp_valid, 1);
      cycles(1);
      check("nan_fflags", fflags, 5'b10000);

      // +Inf -> UINT32 with dynamic rm; frm change after accept must not matter
      frm = 3'b001;
      send(64'h7FF0000000000000, 2'b01, 2'b11, 3'b111, 5'd5, 32'hFFFFFFFF, 5'b10100, 1'b0);
      frm = 3'b010;
      check("dyn_cvt_rm", cvt_rm, 3'b001);
      cycles(3);
      check("inf_fflags", fflags, 5'b10100);

      // illegal rounding modes and FP64 output
      frm = 3'b101;
      send(64'h10, 2'b10, 2'b00, 3'b111, 5'd7, 32'h0, 5'b0, 1'b1);
      check("ill_cvt_rm", cvt_rm, 3'b101);
      send(64'h10, 2'b10, 2'b00, 3'b110, 5'd8, 32'h0, 5'b0, 1'b1);
      send(64'h7FF8000000000000, 2'b01, 2'b01, 3'b000, 5'd9, 32'h0, 5'b0, 1'b1);
      cycles(3);
      check("ill_fflags_kept", fflags, 5'b10100);
      send(64'h100, 2'b10, 2'b00, 3'b011, 5'd10, 32'h103, 5'b00001, 1'b0);
      cycles(3);
      check("nx_fflags", fflags, 5'b10101);

      // sticky flags with clear
      fflags_clr = 1'b1;
      cycles(1);
      fflags_clr = 1'b0;
      check("clr_fflags", fflags, 5'b0);
      send(64'h7FF8000000000000, 2'b01, 2'b10, 3'b000, 5'd11, 32'h80000000, 5'b10000, 1'b0);
      cycles(2);
      check("acc_fflags", fflags, 5'b10000);
      send(64'h7FF0000000000000, 2'b01, 2'b10, 3'b000, 5'd12, 32'h7FFFFFFF, 5'b10100, 1'b0);
      fflags_clr = 1'b1;
      cycles(1);
      fflags_clr = 1'b0;
      check("clr_push_fflags", fflags, 5'b10100);
      fflags_clr = 1'b1;
      cycles(1);
      fflags_clr = 1'b0;
      check("clr_only_fflags", fflags, 5'b0);
      cycles(2);

      // backpressure and ordering
      rsp_ready = 1'b0;
      send(64'h1, 2'b10, 2'b10, 3'b000, 5'd1, 32'h1, 5'b0, 1'b0);
      send(64'h2, 2'b10, 2'b10, 3'b000, 5'd2, 32'h2, 5'b0, 1'b0);
      send(64'h3, 2'b10, 2'b10, 3'b000, 5'd3, 32'h3, 5'b0, 1'b0);
      fork
         send(64'h4, 2'b10, 2'b10, 3'b000, 5'd4, 32'h4, 5'b0, 1'b0);
      join_none
      cycles(3);
      check("bp_req_ready", req_ready, 0);
      check("bp_s1_holds_3", cvt_operand, 64'h3);
      check("bp_head_tag", rsp_tag, 5'd1);
      rsp_ready = 1'b1;
      cycles(1);
      // push and pop at count 2: FIFO must still be full
      rsp_ready = 1'b0;
      check("full_pp_head_tag", rsp_tag, 5'd2);
      check("full_pp_s1_holds_4", cvt_operand, 64'h4);
      #1;
      check("full_pp_req_ready", req_ready, 0);
      rsp_ready = 1'b1;
      cycles(5);
      check("bp_drained", exp_q.size(), 0);

      // reset mid-flight
      rsp_ready = 1'b0;
      send(64'h7FF8000000000000, 2'b01, 2'b10, 3'b000, 5'd20, 32'h80000000, 5'b10000, 1'b0);
      send(64'h21, 2'b10, 2'b10, 3'b000, 5'd21, 32'h21, 5'b0, 1'b0);
      send(64'h22, 2'b10, 2'b10, 3'b000, 5'd22, 32'h22, 5'b0, 1'b0);
      check("mid_fflags", fflags, 5'b10000);
      check("mid_req_ready", req_ready, 0);
      rst = 1'b1;
      rsp_ready = 1'b1;
      exp_q.delete();
      cycles(1);
      check("mid_rst_req_ready", req_ready, 0);
      rst = 1'b0;
      #1;
      check("mid_rsp_valid", rsp_valid, 0);
      check("mid_fflags_cleared", fflags, 5'b0);
      check("mid_req_ready_after", req_ready, 1);
      cycles(4);
      check("mid_no_stale", rsp_valid, 0);
      send(64'h30, 2'b10, 2'b00, 3'b001, 5'd25, 32'h31, 5'b00001, 1'b0);
      cycles(4);
      check("final_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
